// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit timing.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 868;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered head, flags and count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] head_next;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok      = pop && valid;
        push_ok     = push && (!full || pop_ok);
        rd_ptr_next = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next  = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        head_next   = (push_ok && (wr_ptr == rd_ptr_next)) ? wdata : mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            empty  <= 1'b1;
            full   <= 1'b0;
            rdata  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            valid  <= (count_next != '0);
            empty  <= (count_next == '0);
            full   <= (count_next == CNT_W'(DEPTH));
            if (push_ok || pop_ok) begin
                rdata <= head_next;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronizes and oversamples the RX line, buffers bytes in a FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic                          rx_meta;
    logic                          rx_s;
    uart_rx_state_t                state;
    uart_rx_state_t                state_next;
    logic [CNT_W-1:0]              cnt;
    logic [CNT_W-1:0]              cnt_next;
    logic [2:0]                    bit_idx;
    logic [2:0]                    bit_idx_next;
    logic [UART_DATA_BITS-1:0]     shreg;
    logic [UART_DATA_BITS-1:0]     shreg_next;
    logic                          push;
    logic                          pop;
    logic                          frame_err_next;
    logic                          overrun_next;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          unused_fifo_status;

    assign pop                = o_valid && i_ready;
    assign unused_fifo_status = ^{fifo_empty, fifo_count};

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bit_idx     <= bit_idx_next;
            shreg       <= shreg_next;
            o_frame_err <= frame_err_next;
            o_overrun   <= overrun_next;
            o_busy      <= (state_next != IDLE);
        end
    end

    // Start bit is checked at mid-bit; every later sample is one full bit period on.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        bit_idx_next   = bit_idx;
        shreg_next     = shreg;
        push           = 1'b0;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF_LAST) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        cnt_next     = '0;
                        bit_idx_next = '0;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s, shreg[UART_DATA_BITS-1:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    if (rx_s) begin
                        state_next   = IDLE;
                        push         = 1'b1;
                        overrun_next = fifo_full && !pop;
                    end else begin
                        state_next     = WAIT_HIGH;
                        frame_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .rdata (o_data),
        .valid (o_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_cyc = 0;
    int fe_n  = 0;
    int ov_n  = 0;
    int pop_edge = 0;
    logic [7:0] got[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle; a pop is a cycle with both valid and ready high.
    always @(negedge clk) begin
        if (o_valid) valid_cyc++;
        if (o_valid && i_ready) begin
            got.push_back(o_data);
            pop_edge = cyc + 1;
        end
        if (o_frame_err) fe_n++;
        if (o_overrun) ov_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int idx);
        if (idx < got.size()) return got[idx];
        return 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_rx = frame[i];
            repeat (CPB) tick();
        end
    endtask

    initial begin
        int k;
        int g0;
        int f0;
        int o0;
        int v0;

        rst = 1'b1;
        i_rx = 1'b1;
        i_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs", 32'({o_valid, o_frame_err, o_overrun, o_busy, o_data}), 32'h0);
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // Single byte with exact delivery timing.
        i_ready = 1'b1;
        g0 = got.size(); f0 = fe_n; o0 = ov_n; v0 = valid_cyc;
        k = cyc + 1;
        send_byte(8'h01, 1'b1);
        repeat (4) tick();
        chk("single_count", 32'(got.size() - g0), 32'd1);
        chk("single_data", 32'(get_byte(g0)), 32'h01);
        chk("single_edge", 32'(pop_edge - k), 32'd79);
        chk("single_valid_len", 32'(valid_cyc - v0), 32'd1);
        chk("single_fe", 32'(fe_n - f0), 32'd0);
        chk("single_ov", 32'(ov_n - o0), 32'd0);

        // Short low glitch is rejected at the start-bit check.
        g0 = got.size(); f0 = fe_n; o0 = ov_n; v0 = valid_cyc;
        i_rx = 1'b0;
        repeat (3) tick();
        i_rx = 1'b1;
        repeat (30) tick();
        chk("glitch_valid", 32'(valid_cyc - v0), 32'd0);
        chk("glitch_fe", 32'(fe_n - f0), 32'd0);
        chk("glitch_ov", 32'(ov_n - o0), 32'd0);
        chk("glitch_busy", 32'(o_busy), 32'd0);

        // Framing error, then a held-low line, then a clean byte.
        g0 = got.size(); f0 = fe_n; o0 = ov_n;
        send_byte(8'hA5, 1'b0);
        repeat (20) tick();
        chk("ferr_hold_count", 32'(got.size() - g0), 32'd0);
        i_rx = 1'b1;
        repeat (8) tick();
        send_byte(8'h3C, 1'b1);
        repeat (4) tick();
        chk("ferr_pulses", 32'(fe_n - f0), 32'd1);
        chk("ferr_count", 32'(got.size() - g0), 32'd1);
        chk("ferr_next_data", 32'(get_byte(g0)), 32'h3C);
        chk("ferr_ov", 32'(ov_n - o0), 32'd0);

        // Overrun: fifth byte dropped while nothing drains.
        i_ready = 1'b0;
        g0 = got.size(); o0 = ov_n;
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
        chk("ovr_before", 32'(ov_n - o0), 32'd0);
        send_byte(8'h14, 1'b1);
        chk("ovr_after", 32'(ov_n - o0), 32'd1);
        i_ready = 1'b1;
        repeat (8) tick();
        chk("ovr_drain_count", 32'(got.size() - g0), 32'd4);
        for (int i = 0; i < 4; i++) chk("ovr_drain_data", 32'(get_byte(g0 + i)), 32'h10 + 32'(i));
        chk("ovr_empty", 32'(o_valid), 32'd0);

        // Full FIFO with a pop exactly at the fifth stop sample.
        i_ready = 1'b0;
        g0 = got.size(); o0 = ov_n;
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i), 1'b1);
        fork
            send_byte(8'h24, 1'b1);
            begin
                repeat (78) tick();
                i_ready = 1'b1;
                tick();
                i_ready = 1'b0;
            end
        join
        chk("simpop_ov", 32'(ov_n - o0), 32'd0);
        i_ready = 1'b1;
        repeat (8) tick();
        chk("simpop_count", 32'(got.size() - g0), 32'd5);
        for (int i = 0; i < 5; i++) chk("simpop_data", 32'(get_byte(g0 + i)), 32'h20 + 32'(i));
        chk("simpop_empty", 32'(o_valid), 32'd0);

        // Reset during data bit 4 of 0xFF, then a clean 0x02.
        g0 = got.size(); f0 = fe_n;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (42) tick();
                rst = 1'b1;
                tick();
                @(negedge clk);
                chk("midrst_outputs", 32'({o_valid, o_frame_err, o_overrun, o_busy, o_data}), 32'h0);
                tick();
                rst = 1'b0;
            end
        join
        repeat (10) tick();
        chk("midrst_no_byte", 32'(got.size() - g0), 32'd0);
        chk("midrst_fe", 32'(fe_n - f0), 32'd0);
        send_byte(8'h02, 1'b1);
        repeat (4) tick();
        chk("midrst_next_count", 32'(got.size() - g0), 32'd1);
        chk("midrst_next_data", 32'(get_byte(g0)), 32'h02);
        chk("final_busy", 32'(o_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
